// File: rtl/pdm_decimator.sv
// Boxcar (sinc1) PDM decimator: counts ones over 2^WIDTH qualified bits.
// Optional input synchronizer enabled by PDM_DECIMATOR_SYNC_EN.
module pdm_decimator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             restart,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             ovr_clr
);

  logic             w_bit;
  logic             w_en;
  logic             w_wend;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sample;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovr;

`ifdef PDM_DECIMATOR_SYNC_EN
  logic [1:0] r_bin_sync;
  logic [1:0] r_ben_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin_sync <= '0;
      r_ben_sync <= '0;
    end else begin
      r_bin_sync <= {r_bin_sync[0], bit_in};
      r_ben_sync <= {r_ben_sync[0], bit_en};
    end
  end

  assign w_bit = r_bin_sync[1];
  assign w_en  = r_ben_sync[1];
`else
  assign w_bit = bit_in;
  assign w_en  = bit_en;
`endif

  // restart discards the bit and suppresses a coincident window end
  assign w_wend = w_en && !restart && (r_cnt == {WIDTH{1'b1}});
  assign w_sum  = r_acc + {{WIDTH{1'b0}}, w_bit};

  // 2^WIDTH ones saturates to all-ones
  assign w_sample = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

  assign w_load = w_wend && (!r_valid || out_ready);
  assign w_drop = w_wend && r_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (restart) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_en) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_wend ? '0 : w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_sample;
      r_valid <= 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
    end else if (ovr_clr) begin
      r_ovr <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: window-count reference model
// plus directed loopback, saturation, gap, overrun, restart and reset cases.
module tb_pdm_decimator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_en = 1'b0;
  logic       restart = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       overrun;
  logic       ovr_clr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  pdm_decimator #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_en    (bit_en),
    .restart   (restart),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: counts qualified bits and ones, emits min(ones,255)
  int   m_bits;
  int   m_ones;
  bit   m_valid;
  int   m_data;
  bit   m_ovr;
  bit   d_b [2];
  bit   d_e [2];

  always @(posedge clk or negedge rst_n) begin
    bit b;
    bit e;
    bit wend;
    int samp;
    if (!rst_n) begin
      m_bits = 0; m_ones = 0;
      m_valid = 0; m_data = 0; m_ovr = 0;
      d_b[0] = 0; d_b[1] = 0; d_e[0] = 0; d_e[1] = 0;
    end else begin
`ifdef PDM_DECIMATOR_SYNC_EN
      b = d_b[1]; e = d_e[1];
      d_b[1] = d_b[0]; d_e[1] = d_e[0];
      d_b[0] = bit_in; d_e[0] = bit_en;
`else
      b = bit_in; e = bit_en;
`endif
      wend = 0;
      samp = 0;
      if (restart) begin
        m_bits = 0; m_ones = 0;
      end else if (e) begin
        m_bits += 1;
        m_ones += int'(b);
        if (m_bits == 256) begin
          wend = 1;
          samp = (m_ones > 255) ? 255 : m_ones;
          m_bits = 0; m_ones = 0;
        end
      end
      if (wend && m_valid && !out_ready) begin
        m_ovr = 1;
      end else begin
        if (ovr_clr) m_ovr = 0;
        if (wend) begin
          m_data = samp; m_valid = 1;
        end else if (m_valid && out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_valid", int'(out_valid), int'(m_valid));
      chk("cyc_data", int'(out_data), m_data);
      chk("cyc_ovr", int'(overrun), int'(m_ovr));
    end
  end

  int   n_samp = 0;
  int   last_samp = -1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_samp++;
      last_samp = int'(out_data);
    end
  end

  task automatic drive(input bit b, input bit e, input bit rs = 1'b0);
    bit_in = b;
    bit_en = e;
    restart = rs;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic realign();
    idle(3);
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic settle();
    idle(3);
    @(negedge clk);
    #1;
  endtask

  task automatic run_dac(input logic [7:0] d, input int windows);
    logic [8:0] a;
    int s0;
    a = 9'($urandom_range(0, 255));
    s0 = n_samp;
    realign();
    repeat (256 * windows) begin
      a = {1'b0, a[7:0]} + {1'b0, d};
      drive(a[8], 1'b1);
    end
    settle();
    chk("dac_count", n_samp - s0, windows);
    chk("dac_value", last_samp, int'(d));
  endtask

  task automatic run_const(input bit b, input int exp);
    int s0;
    s0 = n_samp;
    realign();
    repeat (256) drive(b, 1'b1);
    settle();
    chk("const_count", n_samp - s0, 1);
    chk("const_value", last_samp, exp);
  endtask

  initial begin
    int s0;
    idle(2);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ovr", int'(overrun), 0);
    rst_n = 1'b1;
    idle(2);

    run_dac(8'h40, 3);
    run_dac(8'h00, 2);
    run_dac(8'hC3, 3);

    run_const(1'b1, 255);
    run_const(1'b0, 0);

    // gapped input: bit_en every third cycle, alternating 1,0
    s0 = n_samp;
    realign();
    for (int i = 0; i < 256; i++) begin
      drive(((i % 2) == 0), 1'b1);
      idle(2);
    end
    settle();
    chk("gap_count", n_samp - s0, 1);
    chk("gap_value", last_samp, 128);

    // overrun: hold ready low across two window ends
    out_ready = 1'b0;
    realign();
    repeat (256) drive(1'b1, 1'b1);
    repeat (256) drive(1'b0, 1'b1);
    settle();
    chk("ovr_held_valid", int'(out_valid), 1);
    chk("ovr_held_data", int'(out_data), 255);
    chk("ovr_set", int'(overrun), 1);
    ovr_clr = 1'b1;
    drive(1'b0, 1'b0);
    ovr_clr = 1'b0;
    @(negedge clk);
    #1;
    chk("ovr_cleared", int'(overrun), 0);
    realign();
    repeat (255) drive(1'b0, 1'b1);
    ovr_clr = 1'b1;
    drive(1'b0, 1'b1);
    ovr_clr = 1'b0;
    settle();
    chk("ovr_set_wins", int'(overrun), 1);
    chk("ovr_data_kept", int'(out_data), 255);
    out_ready = 1'b1;
    ovr_clr = 1'b1;
    idle(2);
    ovr_clr = 1'b0;

    // restart at bit 100 of an all-ones window
    realign();
    s0 = n_samp;
    repeat (100) drive(1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    repeat (255) drive(1'b1, 1'b1);
    @(negedge clk);
    #1;
    chk("rs_no_early", n_samp - s0, 0);
    drive(1'b1, 1'b1);
    settle();
    chk("rs_count", n_samp - s0, 1);
    chk("rs_value", last_samp, 255);

    // randomized traffic against the model
    realign();
    for (int i = 0; i < 5000; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      ovr_clr = ($urandom_range(0, 49) == 0);
      drive(1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 299) == 0));
    end
    out_ready = 1'b1;
    ovr_clr = 1'b1;
    idle(3);
    ovr_clr = 1'b0;

    // asynchronous reset mid-window with a sample pending
    out_ready = 1'b0;
    realign();
    repeat (256) drive(1'b1, 1'b1);
    repeat (50) drive(1'b1, 1'b1);
    @(negedge clk);
    #1;
    chk("pre_rst_valid", int'(out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_ovr", int'(overrun), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    s0 = n_samp;
    repeat (255) drive(1'b1, 1'b1);
    idle(3);
    chk("post_rst_early", n_samp - s0, 0);
    drive(1'b1, 1'b1);
    settle();
    chk("post_rst_count", n_samp - s0, 1);
    chk("post_rst_value", last_samp, 255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
